// File: rtl/oled_pkg.sv
// Shared constants, state encoding and SSD1306 init table for the OLED init sequencer.
// Latency: n/a (constants and a pure combinational helper).
// Backpressure: n/a.
// Contents: engine instruction encodings, bus address, control byte, sequencer
// state enum, command struct, init table and the step -> command mapping helper.
package oled_pkg;

   localparam logic [1:0] INST_START_TX   = 2'd0;
   localparam logic [1:0] INST_STOP_TX    = 2'd1;
   localparam logic [1:0] INST_READ_BYTE  = 2'd2;
   localparam logic [1:0] INST_WRITE_BYTE = 2'd3;

   localparam logic [6:0] OLED_ADDRESS    = 7'h3C;
   localparam logic [7:0] CTRL_CMD_STREAM = 8'h00;
   // SSD1306 NOP, returned for indices past the end of the table
   localparam logic [7:0] ROM_NOP         = 8'hE3;

   localparam int ROM_DEPTH = 25;
   localparam logic [0:ROM_DEPTH-1][7:0] INIT_TABLE = {
      8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D,
      8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF,
      8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF
   };

   typedef enum logic [2:0] {
      ST_POWERUP_WAIT,
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_CMPL,
      ST_RELEASE,
      ST_FINISH,
      ST_ABORT
   } seqState_t;

   typedef struct packed {
      logic [1:0] inst;
      logic [7:0] data;
   } i2cCmd_t;

   // Step layout: 0 START, 1 address+W, 2 control byte, 3..initLen+2 table, then STOP.
   function automatic i2cCmd_t stepCmd(input int unsigned stepIdx,
                                       input int unsigned initLen,
                                       input logic [7:0]  romByte);
      i2cCmd_t c;
      c.inst = INST_WRITE_BYTE;
      c.data = romByte;
      if (stepIdx == 0) begin
         c.inst = INST_START_TX;
         c.data = 8'h00;
      end else if (stepIdx == 1) begin
         c.data = {OLED_ADDRESS, 1'b0};
      end else if (stepIdx == 2) begin
         c.data = CTRL_CMD_STREAM;
      end else if (stepIdx > initLen + 2) begin
         c.inst = INST_STOP_TX;
         c.data = 8'h00;
      end
      return c;
   endfunction

endpackage

// File: rtl/oled_init_rom.sv
// Init-command table lookup: index -> SSD1306 command byte, NOP beyond INIT_LEN.
// Latency: purely combinational.
// Backpressure: none.
// Ports: idx (table index), data (command byte).
module oled_init_rom
   import oled_pkg::*;
#(
   parameter int INIT_LEN = 25,
   parameter int IDX_W    = 5
) (
   input  logic [IDX_W-1:0] idx,
   output logic [7:0]       data
);

   always_comb begin
      data = ROM_NOP;
      for (int i = 0; i < ROM_DEPTH; i++) begin
         if (i < INIT_LEN && idx == IDX_W'(i)) begin
            data = INIT_TABLE[i];
         end
      end
   end

endmodule

// File: rtl/oled_init_sequencer.sv
// Walks the SSD1306 init table as one I2C transaction through the byte engine.
// Latency: first command POWERUP_CYCLES after reset; 3 cycles overhead between engine commands.
// Backpressure: holds each command (enable/instruction/byte) until the engine reports complete.
// Ports: clk, rst (async, active high), start; busy/done/error status;
//        i2c_instruction/i2c_enable/i2c_byte to the engine, i2c_complete/i2c_nack from it.
// Build option: OLED_NACK_RETRY_EN enables NACK abort with STOP and bounded retries.
module oled_init_sequencer
#(
   parameter int POWERUP_CYCLES = 540000,
   parameter int INIT_LEN       = 25,
   parameter int MAX_RETRIES    = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic [1:0] i2c_instruction,
   output logic       i2c_enable,
   output logic [7:0] i2c_byte,
   input  logic       i2c_complete,
   input  logic       i2c_nack
);
   import oled_pkg::*;

   localparam int STEP_W    = $clog2(INIT_LEN + 4);
   localparam int LAST_STEP = INIT_LEN + 3;
   localparam int CNT_W     = (POWERUP_CYCLES > 1) ? $clog2(POWERUP_CYCLES) : 1;
   localparam seqState_t RESET_STATE = (POWERUP_CYCLES == 0) ? ST_IDLE : ST_POWERUP_WAIT;

   seqState_t         state;
   logic [STEP_W-1:0] step;
   logic [CNT_W-1:0]  delayCnt;
   logic [7:0]        romByte;
   i2cCmd_t           nextCmd;

`ifdef OLED_NACK_RETRY_EN
   localparam int RETRY_W = $clog2(MAX_RETRIES + 2);
   logic [RETRY_W-1:0] retryCnt;
   logic               nackLat;
   logic               aborting;
`else
   localparam int unusedRetryBudget = MAX_RETRIES;
   logic unusedNack;
   assign unusedNack = i2c_nack;
`endif

   // Outputs are loaded on entry to ISSUE so the engine accepts during ISSUE;
   // the ROM is therefore addressed with the byte for step+1 (table index step-2).
   oled_init_rom #(
      .INIT_LEN (INIT_LEN),
      .IDX_W    (STEP_W)
   ) uRom (
      .idx  (step - STEP_W'(2)),
      .data (romByte)
   );

   assign nextCmd = stepCmd(32'(step) + 32'd1, INIT_LEN, romByte);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= RESET_STATE;
         step            <= '0;
         delayCnt        <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         error           <= 1'b0;
         i2c_enable      <= 1'b0;
         i2c_instruction <= INST_START_TX;
         i2c_byte        <= 8'h00;
`ifdef OLED_NACK_RETRY_EN
         retryCnt        <= '0;
         nackLat         <= 1'b0;
         aborting        <= 1'b0;
`endif
      end else begin
         case (state)
            ST_POWERUP_WAIT: begin
               if (start || delayCnt == CNT_W'(POWERUP_CYCLES - 1)) begin
                  state           <= ST_ISSUE;
                  step            <= '0;
                  busy            <= 1'b1;
                  i2c_enable      <= 1'b1;
                  i2c_instruction <= INST_START_TX;
                  i2c_byte        <= 8'h00;
               end else begin
                  delayCnt <= delayCnt + CNT_W'(1);
               end
            end

            ST_IDLE: begin
               if (start) begin
                  state           <= ST_ISSUE;
                  step            <= '0;
                  busy            <= 1'b1;
                  done            <= 1'b0;
                  error           <= 1'b0;
                  i2c_enable      <= 1'b1;
                  i2c_instruction <= INST_START_TX;
                  i2c_byte        <= 8'h00;
`ifdef OLED_NACK_RETRY_EN
                  retryCnt        <= '0;
`endif
               end
            end

            // The engine still shows the previous complete here; it is only
            // looked at from WAIT_CMPL onwards.
            ST_ISSUE: begin
               state <= ST_WAIT_CMPL;
            end

            ST_WAIT_CMPL: begin
               if (i2c_complete) begin
                  state      <= ST_RELEASE;
                  i2c_enable <= 1'b0;
`ifdef OLED_NACK_RETRY_EN
                  if (i2c_instruction == INST_WRITE_BYTE) begin
                     nackLat <= i2c_nack;
                  end
`endif
               end
            end

            ST_RELEASE: begin
               if (step == STEP_W'(LAST_STEP)) begin
`ifdef OLED_NACK_RETRY_EN
                  if (aborting) begin
                     aborting <= 1'b0;
                     retryCnt <= retryCnt + RETRY_W'(1);
                     if (int'(retryCnt) < MAX_RETRIES) begin
                        state           <= ST_ISSUE;
                        step            <= '0;
                        i2c_enable      <= 1'b1;
                        i2c_instruction <= INST_START_TX;
                        i2c_byte        <= 8'h00;
                     end else begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                     end
                  end else begin
                     state <= ST_FINISH;
                  end
`else
                  state <= ST_FINISH;
`endif
               end
`ifdef OLED_NACK_RETRY_EN
               else if (nackLat) begin
                  state <= ST_ABORT;
               end
`endif
               else begin
                  state           <= ST_ISSUE;
                  step            <= step + STEP_W'(1);
                  i2c_enable      <= 1'b1;
                  i2c_instruction <= nextCmd.inst;
                  i2c_byte        <= nextCmd.data;
               end
            end

            ST_FINISH: begin
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= ST_IDLE;
`ifdef OLED_NACK_RETRY_EN
               retryCnt <= '0;
`endif
            end

`ifdef OLED_NACK_RETRY_EN
            // Close the bus with a STOP; RELEASE of that STOP decides retry vs error.
            ST_ABORT: begin
               aborting        <= 1'b1;
               nackLat         <= 1'b0;
               step            <= STEP_W'(LAST_STEP);
               state           <= ST_ISSUE;
               i2c_enable      <= 1'b1;
               i2c_instruction <= INST_STOP_TX;
               i2c_byte        <= 8'h00;
            end
`endif

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_oled_init_sequencer.sv
// Directed bench for oled_init_sequencer with a behavioural I2C byte engine.
// Engine: accepts an enable, drops complete, raises complete 40 cycles later,
// keeps complete high until the next accept, waits for enable low before re-arming.
module tb_oled_init_sequencer;

   localparam int PWR = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       i2c_complete = 1'b0;
   logic       i2c_nack = 1'b0;
   logic       busy, done, error, i2c_enable;
   logic [1:0] i2c_instruction;
   logic [7:0] i2c_byte;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   oled_init_sequencer #(
      .POWERUP_CYCLES (PWR),
      .INIT_LEN       (25),
      .MAX_RETRIES    (3)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .busy            (busy),
      .done            (done),
      .error           (error),
      .i2c_instruction (i2c_instruction),
      .i2c_enable      (i2c_enable),
      .i2c_byte        (i2c_byte),
      .i2c_complete    (i2c_complete),
      .i2c_nack        (i2c_nack)
   );

   logic [7:0] refRom [25] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D,
                               8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF,
                               8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};

   // {instruction, byte} expected for command i of a full sequence
   function automatic logic [9:0] expCmd(input int i);
      if (i == 0)  return {2'd0, 8'h00};
      if (i == 1)  return {2'd3, 8'h78};
      if (i == 2)  return {2'd3, 8'h00};
      if (i <= 27) return {2'd3, refRom[i-3]};
      return {2'd1, 8'h00};
   endfunction

   // ---------------- engine model ----------------
   logic [9:0] cmdLog[$];
   logic [9:0] accCmd = '0;
   int engPh = 0, engCnt = 0, startCnt = 0, stabBad = 0, nackMode = 0;

   always @(posedge clk) begin
      case (engPh)
         0: if (i2c_enable === 1'b1) begin
               accCmd = {i2c_instruction, i2c_byte};
               cmdLog.push_back(accCmd);
               if (i2c_instruction == 2'd0) startCnt++;
               i2c_complete <= 1'b0;
               i2c_nack     <= 1'b0;
               engCnt = 1;
               engPh  = 1;
            end
         1: if (i2c_enable !== 1'b1) begin
               engPh = 0;
            end else begin
               if ({i2c_instruction, i2c_byte} !== accCmd) stabBad++;
               if (engCnt == 40) begin
                  i2c_complete <= 1'b1;
                  i2c_nack     <= (accCmd == 10'h378) &&
                                  (nackMode == 1 || (nackMode == 2 && startCnt == 1));
                  engPh = 2;
               end else begin
                  engCnt++;
               end
            end
         default: if (i2c_enable !== 1'b1) engPh = 0;
      endcase
   end

   // ---------------- handshake monitor ----------------
   int hiRun = 0, loRun = 0, gapBad = 0, shortBad = 0;
   logic prevEn = 1'b0, prevBusy = 1'b0;

   always @(negedge clk) begin
      if (i2c_enable === 1'b1) begin
         if (!prevEn && prevBusy && loRun != 1) gapBad++;
         hiRun++;
         loRun = 0;
      end else begin
         if (prevEn && hiRun < 41) shortBad++;
         hiRun = 0;
         loRun++;
      end
      prevEn   = (i2c_enable === 1'b1);
      prevBusy = (busy === 1'b1);
   end

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulseStart();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic clearMon();
      gapBad = 0;
      shortBad = 0;
      stabBad = 0;
   endtask

   task automatic checkSeq(input string tag, input int base);
      for (int i = 0; i < 29; i++) begin
         chk($sformatf("%s_cmd%0d", tag, i),
             (base + i < cmdLog.size()) ? 32'(cmdLog[base+i]) : 32'hFFFF,
             32'(expCmd(i)));
      end
   endtask

   // Runs until done or error; optionally fires start while steps 10 and 28 are in flight.
   task automatic runToEnd(input int budget, input bit pulses, output bit ok);
      bit s10, s28;
      s10 = 1'b0;
      s28 = 1'b0;
      ok  = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         tick();
         start = 1'b0;
         if (done || error) ok = 1'b1;
         else if (pulses && !s10 && cmdLog.size() == 11) begin start = 1'b1; s10 = 1'b1; end
         else if (pulses && !s28 && cmdLog.size() == 29) begin start = 1'b1; s28 = 1'b1; end
      end
      start = 1'b0;
   endtask

   // Cycle 1 is the cycle in which reset is released; returns the cycle enable is first high.
   task automatic waitEnable(input int budget, output bit ok, output int cyc);
      ok  = 1'b0;
      cyc = 1;
      for (int i = 0; i < budget && !ok; i++) begin
         tick();
         cyc++;
         if (i2c_enable) ok = 1'b1;
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      bit ok;
      int cyc;
      bit reached;

      // reset values
      rst = 1'b1;
      repeat (3) tick();
      chk("rst_busy",  busy, 0);
      chk("rst_done",  done, 0);
      chk("rst_error", error, 0);
      chk("rst_en",    i2c_enable, 0);
      chk("rst_instr", i2c_instruction, 0);
      chk("rst_byte",  i2c_byte, 0);

      // auto-start after the power-up delay
      @(negedge clk);
      rst = 1'b0;
      waitEnable(100, ok, cyc);
      chk("auto_start_seen", ok, 1);
      chk("auto_start_cycle", cyc, 17);
      chk("auto_start_instr", i2c_instruction, 0);
      chk("auto_start_busy", busy, 1);

      // start while busy at step 0, then at steps 10 and 28
      pulseStart();
      runToEnd(3000, 1'b1, ok);
      chk("run1_end", ok, 1);
      chk("run1_done", done, 1);
      chk("run1_busy", busy, 0);
      chk("run1_error", error, 0);
      repeat (20) tick();
      chk("run1_no_requeue_len", cmdLog.size(), 29);
      chk("run1_idle_en", i2c_enable, 0);
      checkSeq("run1", 0);
      chk("run1_gap", gapBad, 0);
      chk("run1_short_enable", shortBad, 0);
      chk("run1_stable", stabBad, 0);

      // re-run from IDLE
      cmdLog.delete();
      clearMon();
      pulseStart();
      chk("rerun_done_clear", done, 0);
      chk("rerun_busy", busy, 1);
      chk("rerun_en", i2c_enable, 1);
      chk("rerun_instr", i2c_instruction, 0);
      runToEnd(3000, 1'b0, ok);
      chk("rerun_end", ok, 1);
      chk("rerun_done", done, 1);
      chk("rerun_len", cmdLog.size(), 29);
      checkSeq("rerun", 0);
      chk("rerun_gap", gapBad, 0);
      chk("rerun_stable", stabBad, 0);

      // async reset while step 12 is waiting for complete
      cmdLog.delete();
      pulseStart();
      reached = 1'b0;
      for (int i = 0; i < 1000 && !reached; i++) begin
         tick();
         if (cmdLog.size() == 13) reached = 1'b1;
      end
      chk("step12_reached", reached, 1);
      repeat (10) tick();
      #2;
      rst = 1'b1;
      #1;
      chk("arst_en", i2c_enable, 0);
      chk("arst_busy", busy, 0);
      repeat (2) tick();
      cmdLog.delete();
      clearMon();
      @(negedge clk);
      rst = 1'b0;
      waitEnable(100, ok, cyc);
      chk("arst_restart_seen", ok, 1);
      chk("arst_restart_cycle", cyc, 17);
      chk("arst_restart_instr", i2c_instruction, 0);
      runToEnd(3000, 1'b0, ok);
      chk("arst_end", ok, 1);
      chk("arst_done", done, 1);
      chk("arst_len", cmdLog.size(), 29);
      checkSeq("arst", 0);

      // NACK on the address byte of every attempt
      cmdLog.delete();
      startCnt = 0;
      nackMode = 1;
      pulseStart();
      runToEnd(12000, 1'b0, ok);
      chk("nack_all_end", ok, 1);
`ifdef OLED_NACK_RETRY_EN
      chk("nack_all_error", error, 1);
      chk("nack_all_done", done, 0);
      chk("nack_all_busy", busy, 0);
      chk("nack_all_len", cmdLog.size(), 12);
      chk("nack_all_starts", startCnt, 4);
      if (cmdLog.size() == 12) begin
         for (int a = 0; a < 4; a++) begin
            chk($sformatf("nack_all_a%0d_start", a), cmdLog[3*a],   10'h000);
            chk($sformatf("nack_all_a%0d_addr", a),  cmdLog[3*a+1], 10'h378);
            chk($sformatf("nack_all_a%0d_stop", a),  cmdLog[3*a+2], 10'h100);
         end
      end
`else
      chk("nack_all_done", done, 1);
      chk("nack_all_error", error, 0);
      chk("nack_all_len", cmdLog.size(), 29);
      checkSeq("nack_all", 0);
`endif

      // NACK only on the first attempt
      cmdLog.delete();
      startCnt = 0;
      nackMode = 2;
      pulseStart();
      runToEnd(12000, 1'b0, ok);
      chk("nack_once_end", ok, 1);
      chk("nack_once_done", done, 1);
      chk("nack_once_error", error, 0);
`ifdef OLED_NACK_RETRY_EN
      chk("nack_once_len", cmdLog.size(), 32);
      chk("nack_once_starts", startCnt, 2);
      if (cmdLog.size() == 32) begin
         chk("nack_once_a0_start", cmdLog[0], 10'h000);
         chk("nack_once_a0_addr",  cmdLog[1], 10'h378);
         chk("nack_once_a0_stop",  cmdLog[2], 10'h100);
      end
      checkSeq("nack_once", 3);
`else
      chk("nack_once_len", cmdLog.size(), 29);
      checkSeq("nack_once", 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/oled_init_sequencer.md
Name: oled_init_sequencer

Overview:
- Upstream command source for the I2C byte engine (START / STOP / WRITE_BYTE handshake).
- After power-up delay or a `start` pulse, walks a fixed SSD1306 init-command table and issues one transaction: START, address 0x3C+W, control byte 0x00, INIT_LEN command bytes, STOP.
- Reports busy/done/error to the top-level OLED controller.

Parameters:
- POWERUP_CYCLES, 540000, clk cycles idle after reset before auto-start (20 ms at 27 MHz); 0 = no auto-start.
- INIT_LEN, 25, number of command bytes taken from the init ROM.
- MAX_RETRIES, 3, retry budget; used only with NACK_RETRY_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  single-cycle request to re-run the sequence; ignored while busy
- busy  out  1  high from first issued command until FINISH/ERROR
- done  out  1  sticky; set on successful STOP, cleared on next start
- error  out  1  sticky; set on NACK abort (NACK_RETRY_EN only), cleared on next start
- i2c_instruction  out  2  0=START, 1=STOP, 3=WRITE_BYTE (2=READ never issued)
- i2c_enable  out  1  command valid to engine
- i2c_byte  out  8  byte for WRITE_BYTE, held stable while enable high
- i2c_complete  in  1  engine finished current command
- i2c_nack  in  1  valid in the cycle i2c_complete rises after a WRITE_BYTE; 1 = slave did not ACK

Behaviour:
- Reset (async, immediate): state=POWERUP_WAIT (IDLE if POWERUP_CYCLES=0); step=0; delay counter=0; retry count=0; busy=0, done=0, error=0, i2c_enable=0, i2c_instruction=0, i2c_byte=0.
- Step index: 0 START; 1 WRITE 0x78; 2 WRITE 0x00; 3..INIT_LEN+2 WRITE rom[step-3]; INIT_LEN+3 STOP. Step width = clog2(INIT_LEN+4).
- POWERUP_WAIT: count to POWERUP_CYCLES-1, then go to ISSUE with step=0.
  - A `start` during the wait skips to ISSUE immediately.
- IDLE: on start, go to ISSUE with step=0 and clear done/error.
- ISSUE (1 cycle):
  - Drive instruction/byte for the current step; raise i2c_enable; busy=1.
  - Go to WAIT_CMPL.
  - Do not sample i2c_complete here: the engine still shows the previous command's complete until it accepts.
- WAIT_CMPL: hold enable, instruction and byte stable until i2c_complete=1, then go to RELEASE.
  - No timeout.
- RELEASE: i2c_enable=0 for exactly one cycle (lets the engine return to idle).
  - Last step: go to FINISH.
  - NACK latched (retry build): go to ABORT.
  - Otherwise: step+1, go to ISSUE.
- Command spacing: 3 cycles of sequencer overhead between consecutive engine commands (ISSUE, observed complete, RELEASE).
- FINISH: busy=0, done=1, go to IDLE.
- `start` while busy: ignored, no queueing.
- Reset mid-transaction: engine sees enable drop; the bus may be left mid-byte, which the next START recovers. No STOP is forced.

Optional Feature:
- Macro: OLED_NACK_RETRY_EN.
- Defined:
  - i2c_nack is latched in WAIT_CMPL for WRITE_BYTE steps.
  - RELEASE then goes to ABORT: issue STOP (normal ISSUE/WAIT/RELEASE), then retry count+1.
  - If count <= MAX_RETRIES: restart at step=0. Otherwise: error=1, busy=0, go to IDLE.
  - Retry count is cleared on start and on FINISH.
- Not defined:
  - i2c_nack is ignored; error stays 0.
  - No ABORT state or retry counter is synthesised.

Decomposition:
- Package oled_pkg:
  - instruction encodings INST_START_TX=0, INST_STOP_TX=1, INST_READ_BYTE=2, INST_WRITE_BYTE=3;
  - OLED_ADDRESS=7'h3C; CTRL_CMD_STREAM=8'h00;
  - sequencer state enum;
  - the 25-entry SSD1306 init table: AE D5 80 A8 3F D3 00 40 8D 14 20 00 A1 C8 DA 12 81 CF D9 F1 DB 40 A4 A6 AF.
- One sub-module oled_init_rom: combinational index -> byte; returns 0xE3 (NOP) for out-of-range index.

Test Plan:
- Bench setup: POWERUP_CYCLES=16; behavioural engine model raises complete 40 cycles after accepting enable.
- Auto-start: reset then release -> first i2c_enable rises at cycle 17 with instruction=0. Byte stream 78,00,AE,D5,...,AF (27 writes), then instruction=1. done=1, busy=0 after final RELEASE.
- Handshake timing: model keeps complete=1 from the prior command -> sequencer does not skip; each enable stays high ≥ 41 cycles; exactly 1 low cycle between commands; i2c_byte stable throughout enable.
- Re-run: start pulse in IDLE -> done clears next cycle, identical 29-command sequence repeats. Start pulses while busy at steps 0, 10, 28 -> no effect.
- Async reset at step 12 mid-WAIT_CMPL -> i2c_enable=0 and busy=0 within the same cycle. Sequence restarts from step 0 after 16 cycles.
- NACK, OLED_NACK_RETRY_EN defined: nack on address byte every attempt -> 4 STOP-terminated attempts, then error=1, done=0. nack only on the first attempt -> second attempt completes, done=1, error=0.
- NACK, macro undefined: same nack stimulus -> single full sequence, done=1, error=0.
